// File: rtl/seq1011_tx_pkg.sv
// Shared constants and state encoding for the 1011 serial transmitter and its golden model.
package seq1011_tx_pkg;

  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         PAT_LEN = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/seq1011_tx_if.sv
// Parallel word handshake into the transmitter: producer is master, transmitter is slave.
interface seq1011_tx_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/seq1011_ref.sv
// Golden 1011 detector: tracks the last three emitted bits and counts matches (saturating).
// Fed with the bit about to be registered onto the line, so exp_y lines up with that bit.
module seq1011_ref
  import seq1011_tx_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_bit,
  input  logic             i_valid,
  output logic             o_exp_y,
  output logic [CNT_W-1:0] o_match_cnt
);

  logic [PAT_LEN-2:0] r_hist;
  logic               r_expY;
  logic [CNT_W-1:0]   r_matchCnt;

  logic [PAT_LEN-2:0] w_histBase;
  logic [PAT_LEN-1:0] w_window;
  logic               w_match;

  // A clear on this edge means the incoming bit is judged against empty history.
  always_comb begin
    w_histBase = i_clear ? '0 : r_hist;
    w_window   = {w_histBase, i_bit};
    w_match    = i_valid && (w_window == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hist     <= '0;
      r_expY     <= 1'b0;
      r_matchCnt <= '0;
    end else begin
      r_expY <= w_match;
      if (i_valid) begin
        r_hist <= w_window[PAT_LEN-2:0];
      end else begin
        r_hist <= w_histBase;
      end
      if (i_clear) begin
        r_matchCnt <= '0;
      end else if (w_match && (r_matchCnt != '1)) begin
        r_matchCnt <= r_matchCnt + CNT_W'(1);
      end
    end
  end

  assign o_exp_y     = r_expY;
  assign o_match_cnt = r_matchCnt;

endmodule

// File: rtl/seq1011_tx.sv
// Serializes WIDTH-bit words MSB first, one bit per clock, with zero-bubble back-to-back
// transfers, and drives the golden 1011 detection pulse for the downstream detector.
module seq1011_tx
  import seq1011_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  seq1011_tx_if.slave      s_in,
  output logic             o_out,
  output logic             o_out_valid,
  output logic             o_exp_y,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bitCnt;
  logic             r_out;
  logic             r_outValid;

  state_t w_nextState;
  logic   w_ready;
  logic   w_accept;
  logic   w_lastBit;
  logic   w_nextBit;
  logic   w_nextValid;

  // r_bitCnt indexes the bit currently on the line; zero marks the last bit of a word.
  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    w_lastBit   = (r_bitCnt == '0);
    case (r_state)
      ST_IDLE:  w_ready = 1'b1;
      ST_SHIFT: w_ready = w_lastBit;
      default:  w_ready = 1'b0;
    endcase
    w_ready  = w_ready & reset;
    w_accept = s_in.valid & w_ready;
    case (r_state)
      ST_IDLE:  if (w_accept) w_nextState = ST_SHIFT;
      ST_SHIFT: if (w_lastBit && !w_accept) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
    w_nextValid = w_accept | ((r_state == ST_SHIFT) && !w_lastBit);
    w_nextBit   = w_accept ? s_in.data[WIDTH-1] : r_shift[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_out      <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_outValid <= w_nextValid;
      if (w_nextValid) begin
        r_out <= w_nextBit;
      end
      if (w_accept) begin
        r_shift  <= s_in.data << 1;
        r_bitCnt <= CW'(WIDTH - 1);
      end else if ((r_state == ST_SHIFT) && !w_lastBit) begin
        r_shift  <= r_shift << 1;
        r_bitCnt <= r_bitCnt - CW'(1);
      end
    end
  end

  seq1011_ref #(
    .CNT_W (CNT_W)
  ) u_ref (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (i_clear),
    .i_bit       (w_nextBit),
    .i_valid     (w_nextValid),
    .o_exp_y     (o_exp_y),
    .o_match_cnt (o_match_cnt)
  );

  assign s_in.ready  = w_ready;
  assign o_out       = r_out;
  assign o_out_valid = r_outValid;
  assign o_busy      = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_seq1011_tx.sv
// Directed bench for seq1011_tx: a CNT_W=16 instance plus a CNT_W=2 instance for saturation,
// both driven with identical stimulus; outputs sampled on the falling edge.
module tb_seq1011_tx;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  always #5 clk = ~clk;

  seq1011_tx_if #(.WIDTH(WIDTH)) inA ();
  seq1011_tx_if #(.WIDTH(WIDTH)) inB ();

  logic        outA, outValidA, expYA, busyA;
  logic [15:0] matchCntA;
  logic        outB, outValidB, expYB, busyB;
  logic [1:0]  matchCntB;

  seq1011_tx #(.WIDTH(WIDTH), .CNT_W(16)) dutA (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (clear),
    .s_in        (inA),
    .o_out       (outA),
    .o_out_valid (outValidA),
    .o_exp_y     (expYA),
    .o_match_cnt (matchCntA),
    .o_busy      (busyA)
  );

  seq1011_tx #(.WIDTH(WIDTH), .CNT_W(2)) dutB (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (clear),
    .s_in        (inB),
    .o_out       (outB),
    .o_out_valid (outValidB),
    .o_exp_y     (expYB),
    .o_match_cnt (matchCntB),
    .o_busy      (busyB)
  );

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d);
    inA.valid = v;
    inA.data  = d;
    inB.valid = v;
    inB.data  = d;
  endtask

  task automatic pulseClear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Sends one isolated word and checks every emitted bit; pulseMask[i] marks exp_y on bit i+1.
  task automatic sendWord(input string tag, input logic [WIDTH-1:0] word, input logic [WIDTH-1:0] pulseMask);
    applyStimulus(1'b1, word);
    tick();
    applyStimulus(1'b0, ~word);
    for (int i = 0; i < WIDTH; i++) begin
      checkOutput($sformatf("%s_out%0d", tag, i), 32'(outA), 32'(word[WIDTH-1-i]));
      checkOutput($sformatf("%s_vld%0d", tag, i), 32'(outValidA), 32'd1);
      checkOutput($sformatf("%s_expy%0d", tag, i), 32'(expYA), 32'(pulseMask[i]));
      checkOutput($sformatf("%s_expyB%0d", tag, i), 32'(expYB), 32'(pulseMask[i]));
      tick();
    end
    checkOutput($sformatf("%s_idle", tag), 32'(outValidA), 32'd0);
    checkOutput($sformatf("%s_idleExpy", tag), 32'(expYA), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] stream;
    logic [15:0] mask;

    reset = 1'b0;
    clear = 1'b0;
    applyStimulus(1'b0, '0);
    @(negedge clk);
    tick();
    tick();
    checkOutput("rst_out", 32'(outA), 32'd0);
    checkOutput("rst_vld", 32'(outValidA), 32'd0);
    checkOutput("rst_expy", 32'(expYA), 32'd0);
    checkOutput("rst_cnt", 32'(matchCntA), 32'd0);
    checkOutput("rst_busy", 32'(busyA), 32'd0);
    checkOutput("rst_ready", 32'(inA.ready), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("rel_ready", 32'(inA.ready), 32'd1);

    // T1: reset three cycles in the middle of a word
    applyStimulus(1'b1, 8'hFF);
    tick();
    applyStimulus(1'b0, 8'h00);
    tick();
    tick();
    checkOutput("t1_busyMid", 32'(busyA), 32'd1);
    checkOutput("t1_vldMid", 32'(outValidA), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t1_ready%0d", i), 32'(inA.ready), 32'd0);
      tick();
      checkOutput($sformatf("t1_out%0d", i), 32'(outA), 32'd0);
      checkOutput($sformatf("t1_vld%0d", i), 32'(outValidA), 32'd0);
      checkOutput($sformatf("t1_expy%0d", i), 32'(expYA), 32'd0);
      checkOutput($sformatf("t1_busy%0d", i), 32'(busyA), 32'd0);
      checkOutput($sformatf("t1_cnt%0d", i), 32'(matchCntA), 32'd0);
    end
    reset = 1'b1;
    tick();
    checkOutput("t1_readyRel", 32'(inA.ready), 32'd1);
    checkOutput("t1_noLeftover", 32'(outValidA), 32'd0);

    // T2: single word with two in-word matches
    sendWord("t2", 8'b1011_0110, 8'h48);
    checkOutput("t2_cnt", 32'(matchCntA), 32'd2);

    // T3: two words back-to-back, valid held, match spanning the word boundary
    pulseClear();
    stream = 16'h05B0;
    mask   = 16'h0900;
    applyStimulus(1'b1, 8'h05);
    tick();
    applyStimulus(1'b1, 8'hB0);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t3_out%0d", i), 32'(outA), 32'(stream[15-i]));
      checkOutput($sformatf("t3_vld%0d", i), 32'(outValidA), 32'd1);
      checkOutput($sformatf("t3_expy%0d", i), 32'(expYA), 32'(mask[i]));
      if (i == 6) checkOutput("t3_notReady", 32'(inA.ready), 32'd0);
      if (i == 7) checkOutput("t3_readyLast", 32'(inA.ready), 32'd1);
      if (i == 8) applyStimulus(1'b0, 8'h00);
      tick();
    end
    checkOutput("t3_idle", 32'(outValidA), 32'd0);
    checkOutput("t3_cnt", 32'(matchCntA), 32'd2);

    // T4: history survives an idle gap
    pulseClear();
    sendWord("t4a", 8'h05, 8'h00);
    repeat (4) begin
      checkOutput("t4_gapVld", 32'(outValidA), 32'd0);
      checkOutput("t4_gapExpy", 32'(expYA), 32'd0);
      tick();
    end
    sendWord("t4b", 8'h80, 8'h01);
    checkOutput("t4_cnt", 32'(matchCntA), 32'd1);

    // T5: clear between the words wipes the history
    pulseClear();
    sendWord("t5a", 8'h05, 8'h00);
    pulseClear();
    sendWord("t5b", 8'h80, 8'h00);
    checkOutput("t5_cnt", 32'(matchCntA), 32'd0);

    // T6: stream 1011011011011 (+000 pad): four pulses, 2-bit counter saturates at 3
    pulseClear();
    sendWord("t6a", 8'b1011_0110, 8'h48);
    sendWord("t6b", 8'b1101_1000, 8'h12);
    checkOutput("t6_cntA", 32'(matchCntA), 32'd4);
    checkOutput("t6_cntSat", 32'(matchCntB), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
